// File: rtl/hv_sw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hv_sw_pkg
// Description : Shared constants and FSM state type for the HV switch
//               serial receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package hv_sw_pkg;

    // Default number of HV switch channels (shift register length)
    localparam int c_SW_WIDTH_DEF = 16;

    // Received-bit counter width; saturates at all-ones
    localparam int                     c_BIT_CNT_W   = 6;
    localparam logic [c_BIT_CNT_W-1:0] c_BIT_CNT_MAX = '1;

    // Serial input channel indices into the synchronizer bank
    localparam int c_NUM_IN  = 4;
    localparam int c_IDX_CLR = 0;
    localparam int c_IDX_LE  = 1;
    localparam int c_IDX_CLK = 2;
    localparam int c_IDX_DIN = 3;

    // Receiver control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } hv_sw_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge_det
// Description : Two-flop synchronizer for one asynchronous input, plus a
//               history flop producing a one-cycle rising-edge pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_hist;

    // Resynchronize the input and keep one cycle of history for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_hist <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    // History resets low, so an input already high after reset yields one edge
    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_hist;

endmodule
`default_nettype wire

// File: rtl/hv_sw_receiver.sv
`default_nettype none
// ============================================================================
// Module      : hv_sw_receiver
// Description : Receives the HV switch serial stream (CLK/DIN/LE/CLR),
//               shifts it into a register and latches it onto sw_state on
//               each latch-enable edge, with frame counting and bit-count
//               error detection.
// Revision    : 1.0 - initial release
// ============================================================================
module hv_sw_receiver
    import hv_sw_pkg::*;
#(
    parameter int SW_WIDTH = c_SW_WIDTH_DEF,
    parameter int FCNT_W   = 8
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic                hv_sw_clr,
    input  logic                hv_sw_le,
    input  logic                hv_sw_clk,
    input  logic                hv_sw_din,
    output logic [SW_WIDTH-1:0] sw_state,
    output logic                sw_valid,
    output logic                bit_cnt_err,
    output logic [FCNT_W-1:0]   frame_cnt,
    output logic                busy
);

    logic [c_NUM_IN-1:0]    w_async;
    logic [c_NUM_IN-1:0]    w_level;
    logic [c_NUM_IN-1:0]    w_rise;
    logic                   w_clr;
    logic                   w_din;
    logic                   w_clk_rise;
    logic                   w_le_rise;
    logic                   w_le_take;
    logic                   w_unused;

    hv_sw_state_e           r_state;
    hv_sw_state_e           w_state_nxt;
    logic [SW_WIDTH-1:0]    r_shift;
    logic [c_BIT_CNT_W-1:0] r_bit_cnt;
    logic [SW_WIDTH-1:0]    r_sw_state;
    logic                   r_sw_valid;
    logic                   r_err;
    logic [FCNT_W-1:0]      r_frame_cnt;

    assign w_async[c_IDX_CLR] = hv_sw_clr;
    assign w_async[c_IDX_LE]  = hv_sw_le;
    assign w_async[c_IDX_CLK] = hv_sw_clk;
    assign w_async[c_IDX_DIN] = hv_sw_din;

    generate
        for (genvar gi = 0; gi < c_NUM_IN; gi++) begin : g_sync
            sync_edge_det u_sync (
                .clk     (clk_in),
                .rst     (reset),
                .i_async (w_async[gi]),
                .o_level (w_level[gi]),
                .o_rise  (w_rise[gi])
            );
        end
    endgenerate

    assign w_clr      = w_level[c_IDX_CLR];
    assign w_din      = w_level[c_IDX_DIN];
    assign w_clk_rise = w_rise[c_IDX_CLK];
    assign w_le_rise  = w_rise[c_IDX_LE];
    // A latch request is ignored entirely while the outputs are held clear
    assign w_le_take  = w_le_rise & ~w_clr;

    // Level of CLK/LE and edges of CLR/DIN are not needed
    assign w_unused = ^{w_level[c_IDX_CLK], w_level[c_IDX_LE],
                        w_rise[c_IDX_CLR], w_rise[c_IDX_DIN]};

    // Control state register
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; leaving LATCH goes to SHIFT if a bit arrived with or after the latch
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_le_take) begin
                    w_state_nxt = ST_LATCH;
                end else if (w_clk_rise) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_le_take) begin
                    w_state_nxt = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (w_le_take) begin
                    w_state_nxt = ST_LATCH;
                end else if (w_clk_rise || (r_bit_cnt != '0)) begin
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Serial shift register and saturating bit counter; a coincident latch restarts the count
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else begin
            if (w_clk_rise) begin
                r_shift <= {r_shift[SW_WIDTH-2:0], w_din};
            end
            if (w_le_take) begin
                r_bit_cnt <= w_clk_rise ? c_BIT_CNT_W'(1) : '0;
            end else if (w_clk_rise && (r_bit_cnt != c_BIT_CNT_MAX)) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    // Output latch, valid pulse, frame counter and sticky bit-count error
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_sw_state  <= '0;
            r_sw_valid  <= 1'b0;
            r_err       <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_sw_valid <= (w_state_nxt == ST_LATCH);
            if (w_clr) begin
                r_sw_state <= '0;
            end else if (w_le_take) begin
                r_sw_state <= r_shift;
            end
            if (w_le_take) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
                if (r_bit_cnt != c_BIT_CNT_W'(SW_WIDTH)) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign sw_state    = r_sw_state;
    assign sw_valid    = r_sw_valid;
    assign bit_cnt_err = r_err;
    assign frame_cnt   = r_frame_cnt;
    assign busy        = (r_state == ST_SHIFT);

endmodule
`default_nettype wire

// File: doc/hv_sw_receiver.md
HV_SW_RECEIVER -- requirements
Module: hv_sw_receiver

Interface
REQ-001 Parameter SW_WIDTH, default 16: number of HV switch channels (shift register length), legal range 2..32.
REQ-002 Parameter FCNT_W, default 8: width of frame counter.
REQ-003 clk_in  input  1  100 MHz system clock, sole clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 hv_sw_clr  input  1  HV switch latch clear, active-high level, asynchronous to clk_in.
REQ-006 hv_sw_le  input  1  latch enable; rising edge transfers shift register to outputs.
REQ-007 hv_sw_clk  input  1  serial shift clock; data sampled on its rising edge.
REQ-008 hv_sw_din  input  1  serial data, driven by the transmit side's HV_SW_DOUT.
REQ-009 sw_state  output  SW_WIDTH  latched switch state; bit k = channel k closed.
REQ-010 sw_valid  output  1  one-cycle pulse when sw_state is loaded by LE.
REQ-011 bit_cnt_err  output  1  sticky flag: LE seen with bit count != SW_WIDTH.
REQ-012 frame_cnt  output  FCNT_W  count of LE latch events, wraps.
REQ-013 busy  output  1  high while FSM in SHIFT.

Function
REQ-014 All four serial inputs SHALL pass a 2-flop synchronizer, then a registered-history rising-edge detector; inputs must hold each level >= 2 clk_in cycles.
REQ-015 Latency: an input rising edge first sampled at clk_in edge E0 SHALL produce its effect (shift, latch, valid) at edge E2.
REQ-016 On hv_sw_clk rising edge: shift_reg <= {shift_reg[SW_WIDTH-2:0], din_sync}; first bit received ends in sw_state[SW_WIDTH-1] after SW_WIDTH shifts.
REQ-017 bit_cnt (6 bits) SHALL increment per shift and saturate at 63.
REQ-018 On hv_sw_le rising edge: sw_state <= shift_reg value before any same-cycle shift; sw_valid = 1 for exactly one cycle; frame_cnt += 1 modulo 2^FCNT_W; bit_cnt <= 0.
REQ-019 Simultaneous clk and LE edges: latch takes pre-shift value, shift still occurs, bit_cnt becomes 1.
REQ-020 At LE edge, if bit_cnt != SW_WIDTH, bit_cnt_err SHALL be set; latch still performed; flag cleared only by reset.
REQ-021 While hv_sw_clr (synced) is high, sw_state SHALL be 0 and LE SHALL NOT load it (sw_valid stays 0, frame_cnt unchanged); shift register and bit_cnt unaffected.
REQ-022 FSM states IDLE, SHIFT, LATCH: IDLE->SHIFT on first clk edge; SHIFT->LATCH on LE edge; LATCH->IDLE next cycle, or LATCH->SHIFT if a clk edge coincided; IDLE->LATCH on LE edge with zero bits (err set).
REQ-023 sw_valid SHALL be registered and asserted only in the LATCH state.

Reset
REQ-024 On reset: sw_state=0, sw_valid=0, bit_cnt_err=0, frame_cnt=0, busy=0, shift_reg=0, bit_cnt=0, FSM=IDLE, synchronizer and history flops=0.
REQ-025 Reset mid-shift SHALL discard partial data; first edge after release is treated as new (history flops=0, so an input already high yields one edge).

Structure
REQ-026 Shared package hv_sw_pkg SHALL hold SW_WIDTH default, FSM state enum, bit_cnt width constant.
REQ-027 Sub-module sync_edge_det (2-flop sync + rising-edge pulse + synced level out) SHALL be instantiated once per serial input.

Verification
REQ-028 Shift 0xA5C3 first-bit-MSB, 16 clocks, LE pulse -> sw_state=0xA5C3, sw_valid one cycle, frame_cnt=1, bit_cnt_err=0.
REQ-029 Shift 15 bits of 0x7FFF then LE -> bit_cnt_err=1, sw_state=0x7FFF, frame_cnt=1.
REQ-030 Shift 17 bits (1 then 0xBEEF) then LE -> sw_state=0xBEEF, bit_cnt_err=1.
REQ-031 Load 0xFFFF, raise CLR, pulse LE with 0x1234 shifted -> sw_state=0, sw_valid=0; drop CLR, pulse LE -> sw_state=0x1234.
REQ-032 Assert reset after 8 shift clocks -> all outputs 0; then full 16-bit frame 0x00FF -> sw_state=0x00FF, err=0.
REQ-033 256 correct frames -> frame_cnt returns to 0, sw_valid pulsed 256 times, err=0.
